// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32IM control unit: state
// encoding, opcode values and datapath mux/trap encodings.
package rv_ctrl_pkg;

    // LUI and AUIPC share S_UPPER so that all states fit in 4 bits.
    // The two differ only in operand A, which is chosen from the opcode.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_UPPER    = 4'd8,
        S_ALU_WB   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JAL      = 4'd11,
        S_JALR     = 4'd12,
        S_MULDIV   = 4'd13,
        S_MD_WAIT  = 4'd14,
        S_TRAP     = 4'd15
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    localparam logic [1:0] CAUSE_NONE        = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL     = 2'b01;
    localparam logic [1:0] CAUSE_BUS_TIMEOUT = 2'b10;

    // States that wait on mem_ready and are covered by the bus timeout.
    function automatic logic isMemWaitState(state_e s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control/status bundle between the sequencer and the multi-cycle datapath.
// The master side is the control unit; the slave side is the datapath.
interface multicycle_control_unit_if;
    logic [6:0] opcode;
    logic       funct7_0;
    logic       mem_ready;
    logic       branch_taken;
    logic       muldiv_done;

    logic       mem_req;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic       muldiv_start;
    logic       trap;
    logic [1:0] trap_cause;
    logic [3:0] state_o;

    modport master (
        input  opcode, funct7_0, mem_ready, branch_taken, muldiv_done,
        output mem_req, iord, mem_write, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, alu_op, result_src, muldiv_start,
               trap, trap_cause, state_o
    );

    modport slave (
        output opcode, funct7_0, mem_ready, branch_taken, muldiv_done,
        input  mem_req, iord, mem_write, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, alu_op, result_src, muldiv_start,
               trap, trap_cause, state_o
    );
endinterface

// File: rtl/ctrl_opclass.sv
// Opcode classifier used in DECODE: maps opcode/funct7_0 to the state that
// follows DECODE and flags opcodes the core does not implement.
module ctrl_opclass
    import rv_ctrl_pkg::*;
#(
    parameter int MULDIV_EN = 1
) (
    input  logic [6:0] i_opcode,
    input  logic       i_funct7_0,
    output state_e     o_nextState,
    output logic       o_illegal
);

    // Anything not recognised falls through to TRAP; M-extension R-types
    // count as illegal when the mul/div unit is not present.
    always_comb begin
        o_nextState = S_TRAP;
        o_illegal   = 1'b1;
        case (i_opcode)
            OP_LOAD, OP_STORE: begin
                o_nextState = S_MEM_ADDR;
                o_illegal   = 1'b0;
            end
            OP_RTYPE: begin
                if (!i_funct7_0) begin
                    o_nextState = S_EXEC_R;
                    o_illegal   = 1'b0;
                end else if (MULDIV_EN != 0) begin
                    o_nextState = S_MULDIV;
                    o_illegal   = 1'b0;
                end
            end
            OP_ITYPE: begin
                o_nextState = S_EXEC_I;
                o_illegal   = 1'b0;
            end
            OP_BRANCH: begin
                o_nextState = S_BRANCH;
                o_illegal   = 1'b0;
            end
            OP_JAL: begin
                o_nextState = S_JAL;
                o_illegal   = 1'b0;
            end
            OP_JALR: begin
                o_nextState = S_JALR;
                o_illegal   = 1'b0;
            end
            OP_LUI, OP_AUIPC: begin
                o_nextState = S_UPPER;
                o_illegal   = 1'b0;
            end
            default: begin
                o_nextState = S_TRAP;
                o_illegal   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32IM sequencer: walks each instruction through fetch,
// decode, execute, memory and writeback, with memory wait states and a
// bus timeout, a mul/div handshake and a sticky trap.
module multicycle_control_unit
    import rv_ctrl_pkg::*;
#(
    parameter int MULDIV_EN   = 1,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    multicycle_control_unit_if.master  bus
);

    localparam int CW = $clog2(MEM_TIMEOUT);

    state_e         r_state;
    state_e         w_nextState;
    state_e         w_decodeNext;
    logic           w_illegal;
    logic [CW-1:0]  r_waitCount;
    logic [1:0]     r_trapCause;
    logic           w_waitState;
    logic           w_timeout;

    logic           w_memReq;
    logic           w_iord;
    logic           w_memWrite;
    logic           w_irWrite;
    logic           w_pcWrite;
    logic           w_regWrite;
    logic [1:0]     w_srcA;
    logic [1:0]     w_srcB;
    logic [1:0]     w_aluOp;
    logic [1:0]     w_resSrc;
    logic           w_mdStart;
    logic           w_trap;

    ctrl_opclass #(
        .MULDIV_EN (MULDIV_EN)
    ) u_opclass (
        .i_opcode    (bus.opcode),
        .i_funct7_0  (bus.funct7_0),
        .o_nextState (w_decodeNext),
        .o_illegal   (w_illegal)
    );

    assign w_waitState = isMemWaitState(r_state);
    assign w_timeout   = w_waitState && !bus.mem_ready &&
                         (r_waitCount == CW'(MEM_TIMEOUT - 1));

    // State register; reset returns to FETCH at once, even mid-access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Wait-state counter: restarts whenever a new state is entered and
    // counts the cycles spent without mem_ready in the memory states.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_waitCount <= '0;
        end else if (w_nextState != r_state) begin
            r_waitCount <= '0;
        end else if (w_waitState && !bus.mem_ready) begin
            r_waitCount <= r_waitCount + CW'(1);
        end
    end

    // Trap cause is captured on the way into TRAP and held until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_trapCause <= CAUSE_NONE;
        end else if ((r_state == S_DECODE) && w_illegal) begin
            r_trapCause <= CAUSE_ILLEGAL;
        end else if (w_timeout) begin
            r_trapCause <= CAUSE_BUS_TIMEOUT;
        end
    end

    // Next-state logic; a timeout in any memory wait state wins over
    // staying, but a mem_ready in the last allowed cycle still completes.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_FETCH: begin
                if (w_timeout)          w_nextState = S_TRAP;
                else if (bus.mem_ready) w_nextState = S_DECODE;
            end
            S_DECODE:   w_nextState = w_decodeNext;
            S_MEM_ADDR: w_nextState = (bus.opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (w_timeout)          w_nextState = S_TRAP;
                else if (bus.mem_ready) w_nextState = S_MEM_WB;
            end
            S_MEM_WB:   w_nextState = S_FETCH;
            S_MEM_WR: begin
                if (w_timeout)          w_nextState = S_TRAP;
                else if (bus.mem_ready) w_nextState = S_FETCH;
            end
            S_EXEC_R:   w_nextState = S_ALU_WB;
            S_EXEC_I:   w_nextState = S_ALU_WB;
            S_UPPER:    w_nextState = S_ALU_WB;
            S_ALU_WB:   w_nextState = S_FETCH;
            S_BRANCH:   w_nextState = S_FETCH;
            S_JAL:      w_nextState = S_ALU_WB;
            S_JALR:     w_nextState = S_ALU_WB;
            S_MULDIV:   w_nextState = S_MD_WAIT;
            S_MD_WAIT: begin
                if (bus.muldiv_done) w_nextState = S_FETCH;
            end
            S_TRAP:     w_nextState = S_TRAP;
            default:    w_nextState = S_FETCH;
        endcase
    end

    // Per-state datapath strobes; everything is forced low while reset is
    // held so the datapath sees no request during an asynchronous reset.
    always_comb begin
        w_memReq   = 1'b0;
        w_iord     = 1'b0;
        w_memWrite = 1'b0;
        w_irWrite  = 1'b0;
        w_pcWrite  = 1'b0;
        w_regWrite = 1'b0;
        w_srcA     = SRCA_PC;
        w_srcB     = SRCB_RS2;
        w_aluOp    = ALUOP_ADD;
        w_resSrc   = RES_ALUOUT;
        w_mdStart  = 1'b0;
        w_trap     = 1'b0;
        if (!rst) begin
            case (r_state)
                S_FETCH: begin
                    w_memReq  = 1'b1;
                    w_srcA    = SRCA_PC;
                    w_srcB    = SRCB_FOUR;
                    w_aluOp   = ALUOP_ADD;
                    w_irWrite = bus.mem_ready;
                    w_pcWrite = bus.mem_ready;
                end
                S_DECODE: begin
                    w_srcA = SRCA_OLDPC;
                    w_srcB = SRCB_IMM;
                end
                S_MEM_ADDR: begin
                    w_srcA = SRCA_RS1;
                    w_srcB = SRCB_IMM;
                end
                S_MEM_RD: begin
                    w_memReq = 1'b1;
                    w_iord   = 1'b1;
                end
                S_MEM_WB: begin
                    w_regWrite = 1'b1;
                    w_resSrc   = RES_MEMDATA;
                end
                S_MEM_WR: begin
                    w_memReq   = 1'b1;
                    w_iord     = 1'b1;
                    w_memWrite = 1'b1;
                end
                S_EXEC_R: begin
                    w_srcA  = SRCA_RS1;
                    w_srcB  = SRCB_RS2;
                    w_aluOp = ALUOP_FUNCT;
                end
                S_EXEC_I: begin
                    w_srcA  = SRCA_RS1;
                    w_srcB  = SRCB_IMM;
                    w_aluOp = ALUOP_FUNCT;
                end
                S_UPPER: begin
                    w_srcA = (bus.opcode == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
                    w_srcB = SRCB_IMM;
                end
                S_ALU_WB: begin
                    w_regWrite = 1'b1;
                    w_resSrc   = RES_ALUOUT;
                end
                S_BRANCH: begin
                    w_srcA    = SRCA_RS1;
                    w_srcB    = SRCB_RS2;
                    w_aluOp   = ALUOP_SUB;
                    w_resSrc  = RES_ALUOUT;
                    w_pcWrite = bus.branch_taken;
                end
                S_JAL: begin
                    w_srcA    = SRCA_OLDPC;
                    w_srcB    = SRCB_FOUR;
                    w_resSrc  = RES_ALUOUT;
                    w_pcWrite = 1'b1;
                end
                S_JALR: begin
                    w_srcA    = SRCA_RS1;
                    w_srcB    = SRCB_IMM;
                    w_resSrc  = RES_ALU;
                    w_pcWrite = 1'b1;
                end
                S_MULDIV: begin
                    w_mdStart = 1'b1;
                end
                S_MD_WAIT: begin
                    w_regWrite = bus.muldiv_done;
                    w_resSrc   = RES_ALUOUT;
                end
                S_TRAP: begin
                    w_trap = 1'b1;
                end
                default: begin
                    w_trap = 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_req      = w_memReq;
    assign bus.iord         = w_iord;
    assign bus.mem_write    = w_memWrite;
    assign bus.ir_write     = w_irWrite;
    assign bus.pc_write     = w_pcWrite;
    assign bus.reg_write    = w_regWrite;
    assign bus.alu_src_a    = w_srcA;
    assign bus.alu_src_b    = w_srcB;
    assign bus.alu_op       = w_aluOp;
    assign bus.result_src   = w_resSrc;
    assign bus.muldiv_start = w_mdStart;
    assign bus.trap         = w_trap;
    assign bus.trap_cause   = r_trapCause;
    assign bus.state_o      = r_state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit. Instructions are issued
// from per-class recipes that expand into one expected control word per
// cycle; a negedge monitor pops and compares those words against the DUT.
module tb_multicycle_control_unit;
    import rv_ctrl_pkg::*;

    typedef struct packed {
        logic       memReq;
        logic       iord;
        logic       memWrite;
        logic       irWrite;
        logic       pcWrite;
        logic       regWrite;
        logic [1:0] srcA;
        logic [1:0] srcB;
        logic [1:0] aluOp;
        logic [1:0] resSrc;
        logic       mdStart;
        logic       trap;
        logic [1:0] cause;
        logic [3:0] state;
    } ctrlWord_t;

    typedef enum logic [3:0] {
        K_R, K_I, K_LUI, K_AUIPC, K_BR, K_JAL, K_JALR, K_LOAD, K_STORE, K_MUL
    } kind_e;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst2 = 1'b1;

    multicycle_control_unit_if bus();
    multicycle_control_unit_if bus2();

    multicycle_control_unit #(.MULDIV_EN(1), .MEM_TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    multicycle_control_unit #(.MULDIV_EN(0), .MEM_TIMEOUT(16)) dutNoMd (
        .clk (clk),
        .rst (rst2),
        .bus (bus2)
    );

    always #5 clk = ~clk;

    int checkCount = 0;
    int errorCount = 0;
    int cycleIdx = 0;
    ctrlWord_t expQ[$];
    ctrlWord_t popped;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic ctrlWord_t actualWord();
        ctrlWord_t w;
        w.memReq   = bus.mem_req;
        w.iord     = bus.iord;
        w.memWrite = bus.mem_write;
        w.irWrite  = bus.ir_write;
        w.pcWrite  = bus.pc_write;
        w.regWrite = bus.reg_write;
        w.srcA     = bus.alu_src_a;
        w.srcB     = bus.alu_src_b;
        w.aluOp    = bus.alu_op;
        w.resSrc   = bus.result_src;
        w.mdStart  = bus.muldiv_start;
        w.trap     = bus.trap;
        w.cause    = bus.trap_cause;
        w.state    = bus.state_o;
        return w;
    endfunction

    // Monitor: every cycle that has an expected word gets compared.
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            popped = expQ.pop_front();
            cycleIdx++;
            checkOutput($sformatf("ctrl word cycle %0d", cycleIdx), 32'(actualWord()), 32'(popped));
        end
    end

    function automatic logic rb();
        return ($urandom_range(0, 1) != 0);
    endfunction

    // Reference recipes for each step of an instruction.
    function automatic ctrlWord_t blank(state_e s);
        ctrlWord_t w = '0;
        w.state = s;
        return w;
    endfunction

    function automatic ctrlWord_t wFetch(logic ready);
        ctrlWord_t w = blank(S_FETCH);
        w.memReq = 1'b1; w.srcB = SRCB_FOUR; w.irWrite = ready; w.pcWrite = ready;
        return w;
    endfunction

    function automatic ctrlWord_t wDecode();
        ctrlWord_t w = blank(S_DECODE);
        w.srcA = SRCA_OLDPC; w.srcB = SRCB_IMM;
        return w;
    endfunction

    function automatic ctrlWord_t wMemAddr();
        ctrlWord_t w = blank(S_MEM_ADDR);
        w.srcA = SRCA_RS1; w.srcB = SRCB_IMM;
        return w;
    endfunction

    function automatic ctrlWord_t wMemAccess(logic isStore);
        ctrlWord_t w = blank(isStore ? S_MEM_WR : S_MEM_RD);
        w.memReq = 1'b1; w.iord = 1'b1; w.memWrite = isStore;
        return w;
    endfunction

    function automatic ctrlWord_t wWriteback(state_e s, logic [1:0] res, logic we);
        ctrlWord_t w = blank(s);
        w.regWrite = we; w.resSrc = res;
        return w;
    endfunction

    function automatic ctrlWord_t wTrap(logic [1:0] cause);
        ctrlWord_t w = blank(S_TRAP);
        w.trap = 1'b1; w.cause = cause;
        return w;
    endfunction

    function automatic ctrlWord_t wExec(kind_e k, logic bt);
        ctrlWord_t w = '0;
        case (k)
            K_R:     begin w = blank(S_EXEC_R); w.srcA = SRCA_RS1; w.srcB = SRCB_RS2; w.aluOp = ALUOP_FUNCT; end
            K_I:     begin w = blank(S_EXEC_I); w.srcA = SRCA_RS1; w.srcB = SRCB_IMM; w.aluOp = ALUOP_FUNCT; end
            K_LUI:   begin w = blank(S_UPPER);  w.srcA = SRCA_ZERO; w.srcB = SRCB_IMM; end
            K_AUIPC: begin w = blank(S_UPPER);  w.srcA = SRCA_OLDPC; w.srcB = SRCB_IMM; end
            K_JAL:   begin w = blank(S_JAL);    w.srcA = SRCA_OLDPC; w.srcB = SRCB_FOUR; w.pcWrite = 1'b1; end
            K_JALR:  begin w = blank(S_JALR);   w.srcA = SRCA_RS1; w.srcB = SRCB_IMM; w.pcWrite = 1'b1; w.resSrc = RES_ALU; end
            K_BR:    begin w = blank(S_BRANCH); w.srcA = SRCA_RS1; w.srcB = SRCB_RS2; w.aluOp = ALUOP_SUB; w.pcWrite = bt; end
            default: begin w = blank(S_MULDIV); w.mdStart = 1'b1; end
        endcase
        return w;
    endfunction

    function automatic logic [6:0] opcodeOf(kind_e k);
        case (k)
            K_R, K_MUL: return OP_RTYPE;
            K_I:        return OP_ITYPE;
            K_LUI:      return OP_LUI;
            K_AUIPC:    return OP_AUIPC;
            K_BR:       return OP_BRANCH;
            K_JAL:      return OP_JAL;
            K_JALR:     return OP_JALR;
            K_LOAD:     return OP_LOAD;
            default:    return OP_STORE;
        endcase
    endfunction

    // One clock cycle: drive inputs, queue the expected word, advance.
    task automatic stepCycle(input logic mr, input logic bt, input logic md, input ctrlWord_t exp);
        bus.mem_ready    = mr;
        bus.branch_taken = bt;
        bus.muldiv_done  = md;
        expQ.push_back(exp);
        @(posedge clk);
        #1;
    endtask

    task automatic waitPhase(input ctrlWord_t wLow, input ctrlWord_t wHigh, input int waits);
        for (int i = 0; i < waits; i++) stepCycle(1'b0, rb(), rb(), wLow);
        stepCycle(1'b1, rb(), rb(), wHigh);
    endtask

    task automatic applyReset(input int cycles);
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) stepCycle(rb(), rb(), rb(), blank(S_FETCH));
        rst = 1'b0;
    endtask

    task automatic trapHold(input logic [1:0] cause, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            bus.opcode = opcodeOf(kind_e'($urandom_range(0, 9)));
            stepCycle(rb(), rb(), rb(), wTrap(cause));
        end
    endtask

    // Issue one instruction: fetch (with waits), decode, then its class path.
    task automatic applyStimulus(input kind_e k, input int fetchWaits, input int memWaits,
                                 input logic bt, input int mdLat);
        bus.opcode   = opcodeOf(k);
        bus.funct7_0 = (k == K_MUL) ? 1'b1 : ((k == K_R) ? 1'b0 : rb());
        waitPhase(wFetch(1'b0), wFetch(1'b1), fetchWaits);
        stepCycle(rb(), rb(), rb(), wDecode());
        case (k)
            K_LOAD: begin
                stepCycle(rb(), rb(), rb(), wMemAddr());
                waitPhase(wMemAccess(1'b0), wMemAccess(1'b0), memWaits);
                stepCycle(rb(), rb(), rb(), wWriteback(S_MEM_WB, RES_MEMDATA, 1'b1));
            end
            K_STORE: begin
                stepCycle(rb(), rb(), rb(), wMemAddr());
                waitPhase(wMemAccess(1'b1), wMemAccess(1'b1), memWaits);
            end
            K_BR: stepCycle(rb(), bt, rb(), wExec(k, bt));
            K_MUL: begin
                stepCycle(rb(), rb(), rb(), wExec(k, 1'b0));
                for (int i = 1; i < mdLat; i++)
                    stepCycle(rb(), rb(), 1'b0, wWriteback(S_MD_WAIT, RES_ALUOUT, 1'b0));
                stepCycle(rb(), rb(), 1'b1, wWriteback(S_MD_WAIT, RES_ALUOUT, 1'b1));
            end
            default: begin
                stepCycle(rb(), rb(), rb(), wExec(k, 1'b0));
                stepCycle(rb(), rb(), rb(), wWriteback(S_ALU_WB, RES_ALUOUT, 1'b1));
            end
        endcase
    endtask

    initial begin
        kind_e k;
        bus.opcode = '0; bus.funct7_0 = 1'b0; bus.mem_ready = 1'b0;
        bus.branch_taken = 1'b0; bus.muldiv_done = 1'b0;
        bus2.opcode = '0; bus2.funct7_0 = 1'b0; bus2.mem_ready = 1'b0;
        bus2.branch_taken = 1'b0; bus2.muldiv_done = 1'b0;
        @(posedge clk);
        #1;
        applyReset(2);

        // Directed cases from the intended use.
        applyStimulus(K_R, 0, 0, 1'b0, 1);
        applyStimulus(K_LOAD, 0, 3, 1'b0, 1);
        applyStimulus(K_BR, 0, 0, 1'b0, 1);
        applyStimulus(K_BR, 0, 0, 1'b1, 1);
        applyStimulus(K_MUL, 0, 0, 1'b0, 5);
        applyStimulus(K_STORE, 0, 0, 1'b0, 1);
        applyStimulus(K_LUI, 0, 0, 1'b0, 1);
        applyStimulus(K_AUIPC, 0, 0, 1'b0, 1);
        applyStimulus(K_JAL, 0, 0, 1'b0, 1);
        applyStimulus(K_JALR, 0, 0, 1'b0, 1);
        applyStimulus(K_I, 0, 0, 1'b0, 1);

        // Random legal instruction stream with short wait states.
        for (int n = 0; n < 60; n++) begin
            k = kind_e'($urandom_range(0, 9));
            applyStimulus(k, $urandom_range(0, 4), $urandom_range(0, 4), rb(), $urandom_range(1, 6));
        end

        // mem_ready on the last allowed cycle completes without a trap.
        applyStimulus(K_R, 15, 0, 1'b0, 1);
        applyStimulus(K_LOAD, 0, 15, 1'b0, 1);
        applyStimulus(K_STORE, 2, 15, 1'b0, 1);

        // Store that never completes: bus timeout after 16 low cycles.
        bus.opcode = OP_STORE;
        waitPhase(wFetch(1'b0), wFetch(1'b1), 0);
        stepCycle(rb(), rb(), rb(), wDecode());
        stepCycle(rb(), rb(), rb(), wMemAddr());
        for (int i = 0; i < 16; i++) stepCycle(1'b0, rb(), rb(), wMemAccess(1'b1));
        trapHold(CAUSE_BUS_TIMEOUT, 4);
        applyReset(1);

        // Illegal opcode traps and stays trapped.
        bus.opcode = 7'b0000000;
        waitPhase(wFetch(1'b0), wFetch(1'b1), 0);
        stepCycle(rb(), rb(), rb(), wDecode());
        trapHold(CAUSE_ILLEGAL, 20);
        applyReset(2);

        // Fetch that never completes traps with a bus timeout.
        bus.opcode = OP_RTYPE;
        for (int i = 0; i < 16; i++) stepCycle(1'b0, rb(), rb(), wFetch(1'b0));
        trapHold(CAUSE_BUS_TIMEOUT, 3);
        applyReset(1);

        // Asynchronous reset in the middle of a store.
        bus.opcode = OP_STORE;
        waitPhase(wFetch(1'b0), wFetch(1'b1), 0);
        stepCycle(rb(), rb(), rb(), wDecode());
        stepCycle(rb(), rb(), rb(), wMemAddr());
        bus.mem_ready = 1'b0;
        expQ.push_back(wMemAccess(1'b1));
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async rst mem_write", 32'(bus.mem_write), 32'd0);
        checkOutput("async rst mem_req", 32'(bus.mem_req), 32'd0);
        checkOutput("async rst state", 32'(bus.state_o), 32'(S_FETCH));
        @(posedge clk);
        #1;
        stepCycle(rb(), rb(), rb(), blank(S_FETCH));
        rst = 1'b0;
        applyStimulus(K_R, 1, 0, 1'b0, 1);

        // Without the M extension, a MUL encoding is an illegal instruction.
        rst2 = 1'b0;
        bus2.opcode = OP_RTYPE;
        bus2.funct7_0 = 1'b1;
        bus2.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("no-M decode state", 32'(bus2.state_o), 32'(S_DECODE));
        @(posedge clk);
        #1;
        checkOutput("no-M trap", 32'(bus2.trap), 32'd1);
        checkOutput("no-M cause", 32'(bus2.trap_cause), 32'(CAUSE_ILLEGAL));
        checkOutput("no-M start", 32'(bus2.muldiv_start), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("no-M sticky state", 32'(bus2.state_o), 32'(S_TRAP));

        checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
